// File: rtl/proc_pkg.sv
// Shared definitions for the base-processor control path: opcodes, timestep
// encoding and instruction field positions.
package proc_pkg;

    localparam int IR_W    = 9;
    localparam int III_LSB = 6;
    localparam int X_LSB   = 3;
    localparam int Y_LSB   = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    function automatic logic [2:0] ir_field(input logic [IR_W-1:0] ir, input int lsb);
        return ir[lsb +: 3];
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; used for register write and bus-drive selects.
module dec3to8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_ctrl.sv
// Control unit of the base processor: fetches a 9-bit instruction in T0 and
// sequences the register file, bus mux and add/sub unit over T1..T3.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int DATAW = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             run,
    input  logic [DATAW-1:0] din,
    output logic             irin,
    output logic [7:0]       rin,
    output logic [7:0]       rout,
    output logic             gout,
    output logic             dinout,
    output logic             ain,
    output logic             gin,
    output logic             sub,
    output logic             done
);

    tstep_e          tstep_q, tstep_d;
    logic [IR_W-1:0] ir_q, ir_d;

    logic [2:0] op, x_sel, y_sel, rout_sel;
    logic       rin_en, rout_en;

    assign op    = ir_field(ir_q, III_LSB);
    assign x_sel = ir_field(ir_q, X_LSB);
    assign y_sel = ir_field(ir_q, Y_LSB);

    // Only the low instruction bits are ever latched; the rest is data-only.
    generate
        if (DATAW > IR_W) begin : g_din_upper
            logic unused_din_upper;
            assign unused_din_upper = ^din[DATAW-1:IR_W];
        end
    endgenerate

    // Every control is forced low while resetn is asserted, irin included.
    always_comb begin
        irin     = 1'b0;
        gout     = 1'b0;
        dinout   = 1'b0;
        ain      = 1'b0;
        gin      = 1'b0;
        sub      = 1'b0;
        done     = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_sel = y_sel;
        if (resetn) begin
            case (tstep_q)
                T0: irin = run;
                T1: begin
                    case (op)
                        OP_MV: begin
                            rout_en = 1'b1;
                            rin_en  = 1'b1;
                            done    = 1'b1;
                        end
                        OP_MVI: begin
                            dinout = 1'b1;
                            rin_en = 1'b1;
                            done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            rout_en  = 1'b1;
                            rout_sel = x_sel;
                            ain      = 1'b1;
                        end
                        default: done = 1'b1;
                    endcase
                end
                T2: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        rout_en = 1'b1;
                        gin     = 1'b1;
                        sub     = (op == OP_SUB);
                    end
                end
                T3: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        gout   = 1'b1;
                        rin_en = 1'b1;
                        done   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    dec3to8 u_dec_rin (
        .w  (x_sel),
        .en (rin_en),
        .y  (rin)
    );

    dec3to8 u_dec_rout (
        .w  (rout_sel),
        .en (rout_en),
        .y  (rout)
    );

    always_comb begin
        ir_d    = ir_q;
        tstep_d = tstep_q;
        if (tstep_q == T0) begin
            if (run) begin
                ir_d    = din[IR_W-1:0];
                tstep_d = T1;
            end
        end else if (done) begin
            tstep_d = T0;
        end else begin
            tstep_d = tstep_e'(tstep_q + 2'd1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tstep_q <= T0;
            ir_q    <= '0;
        end else begin
            tstep_q <= tstep_d;
            ir_q    <= ir_d;
        end
    end

endmodule
